// File: rtl/data_memory_ctrl_pkg.sv
// Shared encodings and helpers for the data memory controller.
// Size codes, FSM states and the store byte-strobe function.
package dmem_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size,
                                                       input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
            SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Load/store request and response channel between the LSU and the data memory.
interface data_memory_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl_lane_align.sv
// Byte-lane steering: store data replication and strobe, load extract and extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]           size,
    input  logic [1:0]           addr_lo,
    input  logic                 is_unsigned,
    input  logic [31:0]          wdata,
    input  logic [31:0]          rword,
    output logic [31:0]          wdata_rep,
    output logic [NUM_LANES-1:0] strobe,
    output logic [31:0]          rdata
);

    assign strobe = lane_mask(size, addr_lo);

    // Replicate the right-justified store data so every strobed lane sees its byte.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wdata_rep[8*i +: 8] = (size == SZ_BYTE) ? wdata[7:0] :
                                     (size == SZ_HALF) ? wdata[8*(i%2) +: 8] :
                                                         wdata[8*i +: 8];
    end

    logic [15:0] lo16;
    logic        sext;

    assign lo16 = 16'(rword >> {addr_lo, 3'b000});
    assign sext = !is_unsigned;

    always_comb begin
        rdata = rword;
        case (size)
            SZ_BYTE: rdata = {{24{sext & lo16[7]}}, lo16[7:0]};
            SZ_HALF: rdata = {{16{sext & lo16[15]}}, lo16};
            default: rdata = rword;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressed data memory with sized loads/stores, error checks
// and configurable read latency; one request outstanding at a time.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_ctrl_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = 4;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 accept, req_err, we;
    logic [AW-1:0]        widx;
    logic [31:0]          wrep, ld_data;
    logic [NUM_LANES-1:0] strobe;

    assign accept = bus.req_valid && (state == IDLE);
    assign widx   = bus.req_addr[AW+1:2];

    // Bits above the word index only matter for the range check.
    assign req_err = (bus.req_size == 2'b11)
                   | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                   | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]))
                   | (|bus.req_addr[31:AW+2]);

    assign we = rst_n && accept && bus.req_write && !req_err;

    dmem_lane_align u_align (
        .size        (bus.req_size),
        .addr_lo     (bus.req_addr[1:0]),
        .is_unsigned (bus.req_unsigned),
        .wdata       (bus.req_wdata),
        .rword       (mem[widx]),
        .wdata_rep   (wrep),
        .strobe      (strobe),
        .rdata       (ld_data)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    err_d   = req_err;
                    rdata_d = (req_err || bus.req_write) ? 32'd0 : ld_data;
                    if (req_err || bus.req_write || READ_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(READ_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stores commit on the acceptance edge; the array is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (strobe[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a latency-1 and a latency-4 instance checked
// against a byte-level memory model with directed and random traffic.
module tb_data_memory_ctrl;

    localparam int D1 = 256;
    localparam int D4 = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_ctrl_if if1();
    data_memory_ctrl_if if4();

    data_memory_ctrl #(.DEPTH_WORDS(D1), .READ_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    data_memory_ctrl #(.DEPTH_WORDS(D4), .READ_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [2][256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            if1.req_valid = v; if1.req_write = wr; if1.req_size = sz;
            if1.req_unsigned = uns; if1.req_addr = a; if1.req_wdata = wd;
        end else begin
            if4.req_valid = v; if4.req_write = wr; if4.req_size = sz;
            if4.req_unsigned = uns; if4.req_addr = a; if4.req_wdata = wd;
        end
    endtask

    task automatic set_rsp_ready(input int d, input logic v);
        if (d == 0) if1.rsp_ready = v;
        else        if4.rsp_ready = v;
    endtask

    function automatic logic rr(input int d); return d == 0 ? if1.req_ready : if4.req_ready; endfunction
    function automatic logic rv(input int d); return d == 0 ? if1.rsp_valid : if4.rsp_valid; endfunction
    function automatic logic re(input int d); return d == 0 ? if1.rsp_err   : if4.rsp_err;   endfunction
    function automatic logic [31:0] rd(input int d); return d == 0 ? if1.rsp_rdata : if4.rsp_rdata; endfunction

    // One full transaction; expectations come from the byte model before it is updated.
    task automatic txn(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       input string tag, output logic [31:0] got);
        int depth, rl, n, nb, exp_lat, wi;
        logic exp_err;
        logic [31:0] exp_rd, w, v;
        depth = (d == 0) ? D1 : D4;
        rl    = (d == 0) ? 1 : 4;
        exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
                  || ((a >> 2) >= 32'(depth));
        exp_rd = 32'd0;
        exp_lat = 1;
        if (!exp_err) begin
            wi = int'(a >> 2);
            if (wr) begin
                nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
                for (int k = 0; k < nb; k++)
                    mdl[d][wi][8*(int'(a[1:0]) + k) +: 8] = wd[8*k +: 8];
            end else begin
                exp_lat = rl;
                w = mdl[d][wi];
                v = w >> (8 * int'(a[1:0]));
                if (sz == 2'b00)      exp_rd = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
                else if (sz == 2'b01) exp_rd = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else                  exp_rd = w;
            end
        end
        n = 0;
        while (!rr(d) && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, " req_ready"}, 32'(rr(d)), 32'd1);
        if (hold > 0) set_rsp_ready(d, 1'b0);
        drive(d, 1'b1, wr, sz, uns, a, wd);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        n = 1;
        while (!rv(d) && n < 50) begin @(posedge clk); #1; n++; end
        got = rd(d);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " rdata"}, rd(d), exp_rd);
        check({tag, " err"}, 32'(re(d)), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(rv(d)), 32'd1);
            check({tag, " hold rdata"}, rd(d), exp_rd);
            check({tag, " hold req_ready"}, 32'(rr(d)), 32'd0);
        end
        set_rsp_ready(d, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        int d, n, depth;
        logic wr, uns;
        logic [1:0] sz;
        logic [31:0] a;

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++) mdl[i][j] = 32'd0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset req_ready", 32'(rr(i)), 32'd1);
            check("reset rsp_valid", 32'(rv(i)), 32'd0);
            check("reset rsp_rdata", rd(i), 32'd0);
            check("reset rsp_err", 32'(re(i)), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency-1 instance, directed cases.
        txn(0, 1, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, "sw0", got);
        txn(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, "lw0", got);
        check("lw0 const", got, 32'hDEADBEEF);
        txn(0, 1, 2'b10, 0, 32'h4, 32'hCAFEBABE, 0, "sw4", got);
        txn(0, 1, 2'b00, 0, 32'h5, 32'h00000011, 0, "sb5", got);
        txn(0, 0, 2'b10, 0, 32'h4, 32'h0, 0, "lw4", got);
        check("lw4 const", got, 32'hCAFE11BE);
        txn(0, 0, 2'b00, 0, 32'h7, 32'h0, 0, "lb7", got);
        check("lb7 const", got, 32'hFFFFFFCA);
        txn(0, 0, 2'b00, 1, 32'h7, 32'h0, 0, "lbu7", got);
        check("lbu7 const", got, 32'h000000CA);
        txn(0, 1, 2'b01, 0, 32'h8, 32'h00008001, 0, "sh8", got);
        txn(0, 0, 2'b01, 0, 32'h8, 32'h0, 0, "lh8", got);
        check("lh8 const", got, 32'hFFFF8001);
        txn(0, 0, 2'b01, 1, 32'hA, 32'h0, 0, "lhuA", got);
        check("lhuA const", got, 32'h00000000);
        txn(0, 1, 2'b10, 0, 32'h2, 32'h12345678, 0, "sw2 err", got);
        txn(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, "lw0 after err", got);
        check("lw0 after err const", got, 32'hDEADBEEF);
        txn(0, 0, 2'b01, 0, 32'h3, 32'h0, 0, "lh3 err", got);
        txn(0, 0, 2'b10, 0, 32'(D1 * 4), 32'h0, 0, "lw oor", got);
        txn(0, 0, 2'b11, 0, 32'h10, 32'h0, 0, "size11 ld", got);
        txn(0, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 0, "size11 st", got);
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, "lw10", got);
        check("lw10 const", got, 32'h0);

        // Latency-4 instance: latency, backpressure, reset during WAIT.
        txn(1, 1, 2'b10, 0, 32'h0, 32'h12345678, 0, "l4 sw0", got);
        txn(1, 0, 2'b10, 0, 32'h0, 32'h0, 3, "l4 lw0 bp", got);
        check("l4 lw0 const", got, 32'h12345678);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("l4 wait valid", 32'(rv(1)), 32'd0);
        check("l4 wait req_ready", 32'(rr(1)), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("l4 midrst valid", 32'(rv(1)), 32'd0);
        check("l4 midrst req_ready", 32'(rr(1)), 32'd1);
        check("l4 midrst rdata", rd(1), 32'd0);
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin @(posedge clk); #1; if (rv(1)) n++; end
        check("l4 no stale rsp", 32'(n), 32'd0);
        txn(1, 0, 2'b10, 0, 32'h0, 32'h0, 0, "l4 lw0 post rst", got);
        check("l4 survive const", got, 32'h12345678);
        txn(0, 0, 2'b10, 0, 32'h4, 32'h0, 0, "l1 lw4 post rst", got);
        check("l1 survive const", got, 32'hCAFE11BE);

        // Random traffic on both instances.
        for (int it = 0; it < 300; it++) begin
            d     = $urandom_range(0, 1);
            depth = (d == 0) ? D1 : D4;
            wr    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            sz    = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a     = 32'($urandom_range(0, depth + 3)) << 2;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            else if (sz == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            else if (sz == 2'b01) a[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) a[31] = 1'b1;
            txn(d, wr, sz, uns, a, $urandom, $urandom_range(0, 2), "rand", got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
